// File: rtl/sweep_pkg.sv
// Shared types and defaults for the bouncing sweep counter controller.
package sweep_pkg;

    localparam int SWEEP_WIDTH     = 8;
    localparam int SWEEP_TURN_W    = 8;
    localparam int SWEEP_DEF_LO    = 7;
    localparam int SWEEP_DEF_HI    = 210;
    localparam int SWEEP_DEF_STEP  = 7;
    localparam int SWEEP_DEF_TURNS = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sweep_state_t;

    typedef struct packed {
        logic [SWEEP_WIDTH-1:0]  lo;
        logic [SWEEP_WIDTH-1:0]  hi;
        logic [SWEEP_WIDTH-1:0]  step;
        logic [SWEEP_TURN_W-1:0] turns;
    } sweep_cfg_t;

endpackage

// File: rtl/sweep_counter_ctrl_step.sv
// Combinational single-step of the bouncing counter: next value, direction
// and whether this step is a reversal.
module sweep_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next_count,
    output logic             next_dir,
    output logic             turn
);

    // One extra bit so neither bound compare can wrap.
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] lo_plus;

    assign up_sum  = {1'b0, count} + {1'b0, step};
    assign lo_plus = {1'b0, lo} + {1'b0, step};

    always_comb begin
        next_count = count;
        next_dir   = dir;
        turn       = 1'b0;
        if (dir) begin
            if (up_sum <= {1'b0, hi}) begin
                next_count = up_sum[WIDTH-1:0];
            end else begin
                next_count = count - step;
                next_dir   = 1'b0;
                turn       = 1'b1;
            end
        end else begin
            if ({1'b0, count} >= lo_plus) begin
                next_count = count - step;
            end else begin
                next_count = up_sum[WIDTH-1:0];
                next_dir   = 1'b1;
                turn       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Sequenced bouncing up/down counter: shadow config, start/pause/abort FSM,
// reversal counting with done pulse and invalid-config error pulse.
module sweep_counter_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH     = SWEEP_WIDTH,
    parameter int TURN_W    = SWEEP_TURN_W,
    parameter int DEF_LO    = SWEEP_DEF_LO,
    parameter int DEF_HI    = SWEEP_DEF_HI,
    parameter int DEF_STEP  = SWEEP_DEF_STEP,
    parameter int DEF_TURNS = SWEEP_DEF_TURNS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [WIDTH-1:0]  cfg_lo,
    input  logic [WIDTH-1:0]  cfg_hi,
    input  logic [WIDTH-1:0]  cfg_step,
    input  logic [TURN_W-1:0] cfg_turns,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [WIDTH-1:0]  DEF_LO_V    = DEF_LO[WIDTH-1:0];
    localparam logic [WIDTH-1:0]  DEF_HI_V    = DEF_HI[WIDTH-1:0];
    localparam logic [WIDTH-1:0]  DEF_STEP_V  = DEF_STEP[WIDTH-1:0];
    localparam logic [TURN_W-1:0] DEF_TURNS_V = DEF_TURNS[TURN_W-1:0];
    localparam logic [TURN_W-1:0] TURN_ONE    = 1;

    sweep_state_t      state_reg, state_next;
    logic [WIDTH-1:0]  lo_reg, hi_reg, step_reg;
    logic [TURN_W-1:0] turns_cfg_reg;
    logic [WIDTH-1:0]  count_reg, count_next;
    logic              dir_reg, dir_next;
    logic [TURN_W-1:0] turn_cnt_reg, turn_cnt_next, turn_cnt_inc;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              cfg_valid;
    logic [WIDTH-1:0]  step_count;
    logic              step_dir;
    logic              step_turn;

    sweep_step #(.WIDTH(WIDTH)) u_step (
        .count      (count_reg),
        .dir        (dir_reg),
        .lo         (lo_reg),
        .hi         (hi_reg),
        .step       (step_reg),
        .next_count (step_count),
        .next_dir   (step_dir),
        .turn       (step_turn)
    );

    assign cfg_valid = (step_reg != '0) && (lo_reg < hi_reg) &&
                       ((hi_reg - lo_reg) >= step_reg);

    // Saturating so endless mode never wraps back to a small value.
    assign turn_cnt_inc = (&turn_cnt_reg) ? turn_cnt_reg : turn_cnt_reg + TURN_ONE;

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        dir_next      = dir_reg;
        turn_cnt_next = turn_cnt_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!abort && !pause && start) begin
                    if (cfg_valid) begin
                        count_next    = lo_reg;
                        dir_next      = 1'b1;
                        turn_cnt_next = '0;
                        state_next    = RUN;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (pause) begin
                    state_next = PAUSE;
                end else begin
                    count_next = step_count;
                    dir_next   = step_dir;
                    if (step_turn) begin
                        turn_cnt_next = turn_cnt_inc;
                        if (turns_cfg_reg != '0 && turn_cnt_inc == turns_cfg_reg) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (!pause && start) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            dir_reg       <= 1'b1;
            turn_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            lo_reg        <= DEF_LO_V;
            hi_reg        <= DEF_HI_V;
            step_reg      <= DEF_STEP_V;
            turns_cfg_reg <= DEF_TURNS_V;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            dir_reg      <= dir_next;
            turn_cnt_reg <= turn_cnt_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            // A start in the same cycle already used the old values above.
            if (state_reg == IDLE && cfg_we) begin
                lo_reg        <= cfg_lo;
                hi_reg        <= cfg_hi;
                step_reg      <= cfg_step;
                turns_cfg_reg <= cfg_turns;
            end
        end
    end

    assign count = count_reg;
    assign dir   = dir_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Self-checking bench: directed scenarios plus randomized commands, all
// compared every cycle against an integer behavioural model.
module tb_sweep_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_lo = '0, cfg_hi = '0, cfg_step = '0, cfg_turns = '0;
    logic       start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [7:0] count;
    logic       dir, busy, done, err;

    int total = 0;
    int bad   = 0;

    // Behavioural model: 0 = idle, 1 = running, 2 = paused
    int m_mode, m_count, m_dir, m_turns, m_done, m_err;
    int m_lo, m_hi, m_step, m_goal;

    always #5 clk = ~clk;

    sweep_counter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_lo    (cfg_lo),
        .cfg_hi    (cfg_hi),
        .cfg_step  (cfg_step),
        .cfg_turns (cfg_turns),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .count     (count),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the sweep rules to the model for one rising edge using the current inputs.
    task automatic model_edge();
        bit rev;
        m_done = 0;
        m_err  = 0;
        if (rst) begin
            m_mode = 0; m_count = 0; m_dir = 1; m_turns = 0;
            m_lo = 7; m_hi = 210; m_step = 7; m_goal = 0;
            return;
        end
        if (m_mode == 0) begin
            if (start && !abort && !pause) begin
                if (m_step != 0 && m_lo < m_hi && (m_hi - m_lo) >= m_step) begin
                    m_count = m_lo; m_dir = 1; m_turns = 0; m_mode = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (cfg_we) begin
                m_lo = cfg_lo; m_hi = cfg_hi; m_step = cfg_step; m_goal = cfg_turns;
            end
        end else if (m_mode == 1) begin
            if (abort) m_mode = 0;
            else if (pause) m_mode = 2;
            else begin
                rev = 0;
                if (m_dir == 1) begin
                    if (m_count + m_step <= m_hi) m_count += m_step;
                    else begin m_count -= m_step; m_dir = 0; rev = 1; end
                end else begin
                    if (m_count >= m_lo + m_step) m_count -= m_step;
                    else begin m_count += m_step; m_dir = 1; rev = 1; end
                end
                if (rev) begin
                    if (m_turns < 255) m_turns++;
                    if (m_goal != 0 && m_turns == m_goal) begin
                        m_done = 1; m_mode = 0;
                    end
                end
            end
        end else begin
            if (abort) m_mode = 0;
            else if (!pause && start) m_mode = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("count", count, m_count);
        check("dir", dir, m_dir);
        check("busy", busy, (m_mode != 0));
        check("done", done, m_done);
        check("err", err, m_err);
    endtask

    task automatic write_cfg(input int lo, input int hi, input int st, input int tn);
        cfg_lo = lo; cfg_hi = hi; cfg_step = st; cfg_turns = tn;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        m_mode = 0; m_count = 0; m_dir = 1; m_turns = 0; m_done = 0; m_err = 0;
        m_lo = 7; m_hi = 210; m_step = 7; m_goal = 0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_dir", dir, 1);
        check("rst_busy", busy, 0);
        $display("reset: count=%0d dir=%0d busy=%0d", count, dir, busy);

        // Defaults with two reversals
        write_cfg(7, 210, 7, 2);
        pulse_start();
        check("t0_count", count, 7);
        check("t0_busy", busy, 1);
        repeat (29) tick();
        check("t29_count", count, 210);
        tick();
        check("t30_count", count, 203);
        check("t30_dir", dir, 0);
        repeat (28) tick();
        check("t58_count", count, 7);
        tick();
        check("t59_count", count, 14);
        check("t59_dir", dir, 1);
        check("t59_done", done, 1);
        check("t59_busy", busy, 0);
        tick();
        check("done_width", done, 0);
        $display("sweep 7..210 step 7 turns 2: final count=%0d", count);

        // Small sweep, one reversal
        write_cfg(0, 10, 4, 1);
        pulse_start();
        check("s_c0", count, 0);
        tick(); check("s_c1", count, 4);
        tick(); check("s_c2", count, 8);
        tick(); check("s_c3", count, 4);
        check("s_dir3", dir, 0);
        check("s_done3", done, 1);
        check("s_busy3", busy, 0);
        $display("sweep 0..10 step 4 turns 1: final count=%0d", count);

        // Invalid configs
        write_cfg(0, 10, 0, 1);
        pulse_start();
        check("e1_err", err, 1);
        check("e1_busy", busy, 0);
        check("e1_count", count, 4);
        tick();
        check("e1_err_clr", err, 0);
        write_cfg(50, 50, 5, 1);
        pulse_start();
        check("e2_err", err, 1);
        check("e2_count", count, 4);
        tick();
        $display("invalid config starts: count=%0d", count);

        // Pause at 35 then resume
        write_cfg(7, 210, 7, 0);
        pulse_start();
        repeat (4) tick();
        check("p_pre", count, 35);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("p_hold", count, 35);
            check("p_busy", busy, 1);
        end
        pause = 1'b0;
        pulse_start();
        check("p_resume", count, 35);
        tick();
        check("p_step", count, 42);
        $display("pause/resume: count=%0d", count);

        // Abort at 91
        abort = 1'b1; tick(); abort = 1'b0;
        write_cfg(0, 200, 7, 0);
        pulse_start();
        repeat (13) tick();
        check("a_pre", count, 91);
        abort = 1'b1; tick(); abort = 1'b0;
        check("a_count", count, 91);
        check("a_busy", busy, 0);
        check("a_done", done, 0);
        $display("abort at 91: count=%0d busy=%0d", count, busy);

        // Reset mid-sweep at 91, then defaults must be back
        pulse_start();
        repeat (13) tick();
        check("r_pre", count, 91);
        rst = 1'b1; tick(); rst = 1'b0;
        check("r_count", count, 0);
        check("r_dir", dir, 1);
        pulse_start();
        check("r_lo_def", count, 7);
        tick();
        check("r_step_def", count, 14);
        $display("reset mid-sweep: defaults restored, count=%0d", count);

        // Config write while running is ignored; pause+abort goes idle
        write_cfg(0, 10, 4, 1);
        pause = 1'b1; abort = 1'b1; tick(); pause = 1'b0; abort = 1'b0;
        check("pa_busy", busy, 0);
        pulse_start();
        check("w_ignored", count, 7);
        abort = 1'b1; tick(); abort = 1'b0;
        $display("cfg write during run ignored: count=%0d", count);

        // Simultaneous cfg write and start: old values run, new values stored
        cfg_lo = 20; cfg_hi = 60; cfg_step = 10; cfg_turns = 1;
        cfg_we = 1'b1; start = 1'b1; tick(); cfg_we = 1'b0; start = 1'b0;
        check("ws_old", count, 7);
        abort = 1'b1; tick(); abort = 1'b0;
        pulse_start();
        check("ws_new", count, 20);
        $display("cfg write with start: second start count=%0d", count);

        // Randomized command stream
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            start = (r < 60);
            pause = (r >= 60 && r < 85);
            abort = (r >= 85 && r < 100);
            rst   = (r == 100);
            cfg_we = (r >= 101 && r < 150);
            if (cfg_we) begin
                cfg_lo    = $urandom_range(0, 200);
                cfg_hi    = $urandom_range(int'(cfg_lo), 255);
                cfg_step  = $urandom_range(0, 30);
                cfg_turns = $urandom_range(0, 4);
            end
            tick();
            if (m_done != 0 || m_err != 0)
                $display("random txn %0d: done=%0d err=%0d count=%0d", i, done, err, count);
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b0; cfg_we = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
